regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_wb_arbiter                                           |
// | Description : Two-requester register-file writeback arbiter. Requester 0 |
// |               is ALU writeback and requester 1 is load writeback. Each     |
// |               requester has a one-entry holding buffer. Contention between |
// |               the buffers is resolved by an alternating priority FSM, and  |
// |               one register write is issued per cycle.                      |
// | Option      : define WB_CONFLICT_COUNT_EN to add a 16-bit saturating       |
// |               counter of cycles with contention (port conflict_cnt).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
`ifdef WB_CONFLICT_COUNT_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  // Priority FSM encoding: which buffer wins when both are occupied.
  localparam logic [0:0] c_PRI0 = 1'b0;
  localparam logic [0:0] c_PRI1 = 1'b1;

  logic [1:0]  r_buf_v;
  logic [4:0]  r_buf_addr0;
  logic [4:0]  r_buf_addr1;
  logic [31:0] r_buf_data0;
  logic [31:0] r_buf_data1;
  logic [0:0]  r_state;
  logic        r_wr_en;
  logic [4:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic [1:0]  w_grant;
  logic [1:0]  w_xfer;

  // Grant selection: a lone occupied buffer wins outright; on contention the FSM decides.
  always_comb begin
    w_grant = 2'b00;
    if (!flush) begin
      if (r_buf_v == 2'b11) begin
        w_grant = (r_state == c_PRI0) ? 2'b01 : 2'b10;
      end else begin
        w_grant = r_buf_v;
      end
    end
  end

  // A buffer accepts when empty or being drained this cycle. The rst_n term
  // keeps both ready outputs low for the whole time reset is asserted.
  assign req0_ready = (~r_buf_v[0] | w_grant[0]) & ~flush & rst_n;
  assign req1_ready = (~r_buf_v[1] | w_grant[1]) & ~flush & rst_n;

  assign w_xfer[0] = req0_valid & req0_ready;
  assign w_xfer[1] = req1_valid & req1_ready;

  // Holding buffers: load on transfer, clear on drain, reload when both coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_v     <= 2'b00;
      r_buf_addr0 <= 5'd0;
      r_buf_addr1 <= 5'd0;
      r_buf_data0 <= 32'd0;
      r_buf_data1 <= 32'd0;
    end else if (flush) begin
      r_buf_v <= 2'b00;
    end else begin
      if (w_xfer[0]) begin
        r_buf_v[0]  <= 1'b1;
        r_buf_addr0 <= req0_addr;
        r_buf_data0 <= req0_data;
      end else if (w_grant[0]) begin
        r_buf_v[0] <= 1'b0;
      end
      if (w_xfer[1]) begin
        r_buf_v[1]  <= 1'b1;
        r_buf_addr1 <= req1_addr;
        r_buf_data1 <= req1_data;
      end else if (w_grant[1]) begin
        r_buf_v[1] <= 1'b0;
      end
    end
  end

  // Priority FSM: the buffer just served yields priority to the other one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_PRI0;
    end else if (w_grant[0]) begin
      r_state <= c_PRI1;
    end else if (w_grant[1]) begin
      r_state <= c_PRI0;
    end
  end

  // Write port register: one-cycle strobe, address/data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= 5'd0;
      r_wr_data <= 32'd0;
    end else begin
      r_wr_en <= |w_grant;
      if (w_grant[0]) begin
        r_wr_addr <= r_buf_addr0;
        r_wr_data <= r_buf_data0;
      end else if (w_grant[1]) begin
        r_wr_addr <= r_buf_addr1;
        r_wr_data <= r_buf_data1;
      end
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;

`ifdef WB_CONFLICT_COUNT_EN
  logic [15:0] r_conflict_cnt;
  logic        w_conflict;

  assign w_conflict = (r_buf_v == 2'b11) & ~flush;

  // Contention counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 16'd0;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_wb_arbiter                                        |
// | Description : Self-checking bench for regfile_wb_arbiter. A vector table  |
// |               covers single writes and sustained contention; hand-written |
// |               sequences cover same-address ordering, flush, mid-operation |
// |               reset and sustained drain/reload. Every write seen on the   |
// |               write port is matched against a scoreboard queue.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
`ifdef WB_CONFLICT_COUNT_EN
  logic [15:0] conflict_cnt;
`endif

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
`ifdef WB_CONFLICT_COUNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [36:0] sb_entry;
  } sb_t;
  sb_t sb_q[$];

  logic [31:0] regs [32];

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        fl;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [15:0] e_cc;
    logic        push;
    logic [4:0]  p_a;
    logic [31:0] p_d;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    sb_t e;
    e.sb_entry = {a, d};
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic fl);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    flush = fl;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  // Waits until all expected writes have appeared and the write port is quiet.
  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !wr_en) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  // Write-port monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write (t=%0t)", wr_addr, wr_data, $time);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("sb_addr", {27'd0, wr_addr}, {27'd0, e.sb_entry[36:32]});
        chk("sb_data", wr_data, e.sb_entry[31:0]);
      end
      regs[wr_addr] <= wr_data;
    end
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;

    //           v0  a0     d0            v1  a1     d1            fl   r0  r1  we  wa     wd            cc     push a      d
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        16'd0, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        16'd0, 1'b0, 5'd0, 32'h0};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 16'd0, 1'b0, 5'd0, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 16'd0, 1'b0, 5'd0, 32'h0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11,      1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 16'd0, 1'b1, 5'd7, 32'h11};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 16'd0, 1'b0, 5'd0, 32'h0};
    tbl[6]  = '{1'b1, 5'd3, 32'hA0,       1'b1, 5'd7, 32'hB0,      1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h11,       16'd0, 1'b1, 5'd3, 32'hA0};
    tbl[7]  = '{1'b1, 5'd3, 32'hA1,       1'b1, 5'd7, 32'hB1,      1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h11,       16'd0, 1'b1, 5'd7, 32'hB0};
    tbl[8]  = '{1'b1, 5'd3, 32'hA2,       1'b1, 5'd7, 32'hB1,      1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hA0,       16'd1, 1'b1, 5'd3, 32'hA1};
    tbl[9]  = '{1'b1, 5'd3, 32'hA2,       1'b1, 5'd7, 32'hB2,      1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hB0,       16'd2, 1'b1, 5'd7, 32'hB1};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'hB2,      1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'hA1,       16'd3, 1'b1, 5'd3, 32'hA2};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'hB1,       16'd4, 1'b1, 5'd7, 32'hB2};
    tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'hA2,       16'd5, 1'b0, 5'd0, 32'h0};
    tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'hB2,       16'd5, 1'b0, 5'd0, 32'h0};
    tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'hB2,       16'd5, 1'b0, 5'd0, 32'h0};

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_wr_en",   {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_ready0",  {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1",  {31'd0, req1_ready}, 32'd0);
`ifdef WB_CONFLICT_COUNT_EN
    chk("rst_cc", {16'd0, conflict_cnt}, 32'd0);
`endif
    rst_n = 1'b1;

    // Table: single-write latency, then sustained contention from PRI0
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      drive(tbl[k].v0, tbl[k].a0, tbl[k].d0, tbl[k].v1, tbl[k].a1, tbl[k].d1, tbl[k].fl);
      if (tbl[k].push) push_wr(tbl[k].p_a, tbl[k].p_d);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready0", k), {31'd0, req0_ready}, {31'd0, tbl[k].e_r0});
      chk($sformatf("tbl%0d_ready1", k), {31'd0, req1_ready}, {31'd0, tbl[k].e_r1});
      chk($sformatf("tbl%0d_wr_en", k),  {31'd0, wr_en}, {31'd0, tbl[k].e_we});
      chk($sformatf("tbl%0d_wr_addr", k), {27'd0, wr_addr}, {27'd0, tbl[k].e_wa});
      chk($sformatf("tbl%0d_wr_data", k), wr_data, tbl[k].e_wd);
`ifdef WB_CONFLICT_COUNT_EN
      chk($sformatf("tbl%0d_cc", k), {16'd0, conflict_cnt}, {16'd0, tbl[k].e_cc});
`endif
    end
    wait_idle("tbl_drain");

    // Same-address ordering from PRI1: a lone buffer-0 write moves FSM to PRI1
    @(posedge clk); #1;
    drive(1'b1, 5'd1, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0);
    push_wr(5'd1, 32'h55);
    idle_cycle();
    wait_idle("pri1_setup");
    @(posedge clk); #1;
    drive(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 1'b0);
    push_wr(5'd9, 32'h2);
    push_wr(5'd9, 32'h1);
    idle_cycle();
    wait_idle("same_addr_drain");
    chk("reg9_final", regs[9], 32'h1);
`ifdef WB_CONFLICT_COUNT_EN
    chk("same_addr_cc", {16'd0, conflict_cnt}, 32'd6);
`endif

    // Flush with both buffers full (FSM is PRI1 here): nothing written
    @(posedge clk); #1;
    drive(1'b1, 5'd10, 32'hF0, 1'b1, 5'd11, 32'hF1, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("flush_ready0", {31'd0, req0_ready}, 32'd0);
    chk("flush_ready1", {31'd0, req1_ready}, 32'd0);
    idle_cycle();
    @(negedge clk);
    chk("post_flush_ready0", {31'd0, req0_ready}, 32'd1);
    chk("post_flush_ready1", {31'd0, req1_ready}, 32'd1);
    chk("post_flush_wr_en",  {31'd0, wr_en}, 32'd0);
    idle_cycle();
    idle_cycle();
    wait_idle("flush_quiet");
`ifdef WB_CONFLICT_COUNT_EN
    chk("flush_cc", {16'd0, conflict_cnt}, 32'd6);
`endif

    // FSM held at PRI1 across flush: buffer 1 goes first; flush then kills
    // buffer 0 but not the write already on the port
    @(posedge clk); #1;
    drive(1'b1, 5'd12, 32'hC0, 1'b1, 5'd13, 32'hC1, 1'b0);
    push_wr(5'd13, 32'hC1);
    idle_cycle();
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("flush_keeps_wr_en", {31'd0, wr_en}, 32'd1);
    chk("flush_keeps_wr_addr", {27'd0, wr_addr}, 32'd13);
    idle_cycle();
    wait_idle("flush_partial");
`ifdef WB_CONFLICT_COUNT_EN
    chk("flush_partial_cc", {16'd0, conflict_cnt}, 32'd7);
`endif

    // Mid-operation reset with both buffers full
    @(posedge clk); #1;
    drive(1'b1, 5'd20, 32'hE0, 1'b1, 5'd21, 32'hE1, 1'b0);
    idle_cycle();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en",  {31'd0, wr_en}, 32'd0);
    chk("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("mid_rst_ready1", {31'd0, req1_ready}, 32'd0);
`ifdef WB_CONFLICT_COUNT_EN
    chk("mid_rst_cc", {16'd0, conflict_cnt}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle_cycle();
    @(negedge clk);
    chk("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd1);
    chk("post_rst_wr_en",  {31'd0, wr_en}, 32'd0);
    chk("reg20_untouched", regs[20], 32'd0);
    wait_idle("post_rst_quiet");

    // Sustained req1 traffic: drain+reload keeps ready high, one write per cycle
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'h100 + 32'(k), 1'b0);
      push_wr(5'(k), 32'h100 + 32'(k));
      @(negedge clk);
      chk($sformatf("stream%0d_ready1", k), {31'd0, req1_ready}, 32'd1);
      if (k >= 2) chk($sformatf("stream%0d_wr_en", k), {31'd0, wr_en}, 32'd1);
    end
    idle_cycle();
    @(negedge clk);
    chk("stream_tail0_wr_en", {31'd0, wr_en}, 32'd1);
    idle_cycle();
    @(negedge clk);
    chk("stream_tail1_wr_en", {31'd0, wr_en}, 32'd1);
    wait_idle("stream_drain");
    chk("reg0_written", regs[0], 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
